// File: rtl/dac_spi_scheduler_if.sv
// Bus between the LFO waveform cores and the DAC SPI scheduler.
// Carries both channel request/data/ack handshakes, the busy flag and the
// three SPI pins that go to GPIO_0[2:0].
//   master : LFO side; drives req/data, observes ack, busy and the SPI pins
//   slave  : scheduler side; observes req/data, drives ack, busy and SPI pins
interface dac_spi_scheduler_if;
    logic        req_a;
    logic [11:0] data_a;
    logic        ack_a;
    logic        req_b;
    logic [11:0] data_b;
    logic        ack_b;
    logic        busy;
    logic        DAC_CSB;
    logic        DAC_SCLK;
    logic        DAC_DIN;

    modport master (
        output req_a, data_a, req_b, data_b,
        input  ack_a, ack_b, busy, DAC_CSB, DAC_SCLK, DAC_DIN
    );

    modport slave (
        input  req_a, data_a, req_b, data_b,
        output ack_a, ack_b, busy, DAC_CSB, DAC_SCLK, DAC_DIN
    );
endinterface

// File: rtl/dac_spi_scheduler.sv
// Shares one dual-channel 12-bit SPI DAC (MCP4922-style, LDAC tied low)
// between two LFO sources. Requests are arbitrated round-robin, the 16-bit
// command word {ch, BUF, GA_N, SHDN_n=1, data[11:0]} is latched on grant and
// shifted out MSB-first.
// Ports:
//   CLOCK_50 : system clock (50 MHz)
//   reset_n  : asynchronous active-low reset; aborts any frame in progress
//   bus      : slave side of dac_spi_scheduler_if
//              req_x/data_x in, ack_x one-cycle capture pulse out,
//              busy out (state != IDLE), DAC_CSB/DAC_SCLK/DAC_DIN out
// Frame timing: CSB low for 33*CLK_DIV cycles (CLK_DIV setup plus 32 SCLK
// half-periods), then high for CS_GAP cycles plus one IDLE cycle.
module dac_spi_scheduler #(
    parameter int unsigned CLK_DIV = 25,
    parameter int unsigned CS_GAP  = 4,
    parameter bit          BUF     = 1'b0,
    parameter bit          GA_N    = 1'b1
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    dac_spi_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [7:0] DIV_LAST_C = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST_C = 8'(CS_GAP - 1);

    state_t      state_r;
    logic        last_grant_r;   // 1'b0 = A granted last, 1'b1 = B
    logic [15:0] shift_r;
    logic [7:0]  cnt_r;          // half-period / setup / gap counter
    logic [3:0]  bit_cnt_r;      // bits still to send after the current one
    logic        ack_a_r;
    logic        ack_b_r;
    logic        busy_r;
    logic        csb_r;
    logic        sclk_r;
    logic        din_r;

    logic        grant_s;
    logic        grant_ch_s;
    logic [15:0] word_s;
    logic        cnt_done_s;

    // Round-robin arbitration and command word assembly for the IDLE grant
    always_comb begin
        grant_s    = 1'b0;
        grant_ch_s = 1'b0;
        if (bus.req_a && bus.req_b) begin
            grant_s    = 1'b1;
            grant_ch_s = ~last_grant_r;
        end else if (bus.req_a) begin
            grant_s    = 1'b1;
            grant_ch_s = 1'b0;
        end else if (bus.req_b) begin
            grant_s    = 1'b1;
            grant_ch_s = 1'b1;
        end else begin
            grant_s    = 1'b0;
            grant_ch_s = 1'b0;
        end
        if (grant_ch_s) begin
            word_s = {1'b1, BUF, GA_N, 1'b1, bus.data_b};
        end else begin
            word_s = {1'b0, BUF, GA_N, 1'b1, bus.data_a};
        end
    end

    // Counter expiry: SETUP and SHIFT phases last CLK_DIV cycles, GAP lasts CS_GAP
    always_comb begin
        cnt_done_s = 1'b0;
        case (state_r)
            SETUP:   cnt_done_s = (cnt_r == DIV_LAST_C);
            SHIFT:   cnt_done_s = (cnt_r == DIV_LAST_C);
            GAP:     cnt_done_s = (cnt_r == GAP_LAST_C);
            default: cnt_done_s = 1'b0;
        endcase
    end

    // Frame sequencer with all outputs registered
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;       // B, so A wins the first tie
            shift_r      <= 16'h0000;
            cnt_r        <= 8'd0;
            bit_cnt_r    <= 4'd0;
            ack_a_r      <= 1'b0;
            ack_b_r      <= 1'b0;
            busy_r       <= 1'b0;
            csb_r        <= 1'b1;
            sclk_r       <= 1'b0;
            din_r        <= 1'b0;
        end else begin
            ack_a_r <= 1'b0;
            ack_b_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        state_r      <= SETUP;
                        shift_r      <= word_s;
                        last_grant_r <= grant_ch_s;
                        ack_a_r      <= ~grant_ch_s;
                        ack_b_r      <= grant_ch_s;
                        busy_r       <= 1'b1;
                        csb_r        <= 1'b0;
                        sclk_r       <= 1'b0;
                        din_r        <= word_s[15];
                        cnt_r        <= 8'd0;
                        bit_cnt_r    <= 4'd15;
                    end else begin
                        busy_r <= 1'b0;
                        csb_r  <= 1'b1;
                        sclk_r <= 1'b0;
                        din_r  <= 1'b0;
                    end
                end
                SETUP: begin
                    if (cnt_done_s) begin
                        state_r <= SHIFT;
                        cnt_r   <= 8'd0;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                SHIFT: begin
                    if (cnt_done_s) begin
                        cnt_r <= 8'd0;
                        if (!sclk_r) begin
                            sclk_r <= 1'b1;
                        end else if (bit_cnt_r == 4'd0) begin
                            // Falling edge after the 16th bit closes the frame
                            sclk_r  <= 1'b0;
                            din_r   <= 1'b0;
                            csb_r   <= 1'b1;
                            state_r <= GAP;
                        end else begin
                            sclk_r    <= 1'b0;
                            shift_r   <= {shift_r[14:0], 1'b0};
                            din_r     <= shift_r[14];
                            bit_cnt_r <= bit_cnt_r - 4'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                GAP: begin
                    if (cnt_done_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        cnt_r   <= 8'd0;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    csb_r   <= 1'b1;
                    sclk_r  <= 1'b0;
                    din_r   <= 1'b0;
                    cnt_r   <= 8'd0;
                end
            endcase
        end
    end

    assign bus.ack_a    = ack_a_r;
    assign bus.ack_b    = ack_b_r;
    assign bus.busy     = busy_r;
    assign bus.DAC_CSB  = csb_r;
    assign bus.DAC_SCLK = sclk_r;
    assign bus.DAC_DIN  = din_r;

endmodule

// File: tb/tb_dac_spi_scheduler.sv
// Directed bench for dac_spi_scheduler with CLK_DIV=2, CS_GAP=4:
// CSB low 66 cycles per frame, frame period 71 cycles.
module tb_dac_spi_scheduler;

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;
    int   cyc;

    dac_spi_scheduler_if bus ();

    dac_spi_scheduler #(
        .CLK_DIV (2),
        .CS_GAP  (4),
        .BUF     (1'b0),
        .GA_N    (1'b1)
    ) dut (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    // Collects the rest of a frame from the grant cycle (CSB already low).
    task automatic finish_frame(output logic [15:0] w, output int low,
                                output int rises, output int acks);
        logic prev;
        w     = 16'h0000;
        low   = 1;
        rises = 0;
        acks  = 0;
        prev  = bus.DAC_SCLK;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (bus.DAC_CSB) break;
            low = low + 1;
            if (!prev && bus.DAC_SCLK) begin
                w     = {w[14:0], bus.DAC_DIN};
                rises = rises + 1;
            end
            acks = acks + int'(bus.ack_a) + int'(bus.ack_b);
            prev = bus.DAC_SCLK;
        end
    endtask

    task automatic apply_reset();
        reset_n    = 1'b0;
        bus.req_a  = 1'b0;
        bus.req_b  = 1'b0;
        bus.data_a = 12'h000;
        bus.data_b = 12'h000;
        tick();
        tick();
        #2;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        int bad;
        apply_reset();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.DAC_CSB !== 1'b1 || bus.DAC_SCLK !== 1'b0 || bus.DAC_DIN !== 1'b0 ||
                bus.busy !== 1'b0 || bus.ack_a !== 1'b0 || bus.ack_b !== 1'b0)
                bad = bad + 1;
        end
        vectors = vectors + 1;
        if (bad !== 0) begin
            miscompares = miscompares + 1;
            $display("FAIL idle_quiet: %0d bad cycles, required 0 (csb=%b sclk=%b din=%b busy=%b)",
                     bad, bus.DAC_CSB, bus.DAC_SCLK, bus.DAC_DIN, bus.busy);
        end
    endtask

    // Single-channel frame: grant, word, CSB timing, gap, return to idle.
    task automatic test_single(input logic ch, input logic [11:0] data,
                               input logic [15:0] exp_word);
        logic [15:0] w;
        int low, rises, acks, bad;
        if (ch) begin bus.req_b = 1'b1; bus.data_b = data; end
        else    begin bus.req_a = 1'b1; bus.data_a = data; end
        tick();
        vectors = vectors + 1;
        if ({bus.ack_a, bus.ack_b} !== {~ch, ch}) begin
            miscompares = miscompares + 1;
            $display("FAIL grant_ack ch%0d: ack_a/ack_b=%b%b, required %b%b",
                     ch, bus.ack_a, bus.ack_b, ~ch, ch);
        end
        vectors = vectors + 1;
        if (bus.DAC_CSB !== 1'b0 || bus.busy !== 1'b1 || bus.DAC_DIN !== exp_word[15]) begin
            miscompares = miscompares + 1;
            $display("FAIL frame_start ch%0d: csb=%b busy=%b din=%b, required 0 1 %b",
                     ch, bus.DAC_CSB, bus.busy, bus.DAC_DIN, exp_word[15]);
        end
        bus.req_a  = 1'b0;
        bus.req_b  = 1'b0;
        bus.data_a = 12'hFFF;
        bus.data_b = 12'hFFF;
        finish_frame(w, low, rises, acks);
        vectors = vectors + 1;
        if (w !== exp_word) begin
            miscompares = miscompares + 1;
            $display("FAIL word ch%0d: got %h, required %h", ch, w, exp_word);
        end
        vectors = vectors + 1;
        if (rises !== 16 || low !== 66) begin
            miscompares = miscompares + 1;
            $display("FAIL frame_timing ch%0d: rises=%0d low=%0d, required 16 66", ch, rises, low);
        end
        vectors = vectors + 1;
        if (acks !== 0) begin
            miscompares = miscompares + 1;
            $display("FAIL ack_single_pulse ch%0d: %0d extra ack cycles, required 0", ch, acks);
        end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            if (bus.DAC_CSB !== 1'b1 || bus.DAC_SCLK !== 1'b0 || bus.busy !== 1'b1) bad = bad + 1;
        end
        tick();
        vectors = vectors + 1;
        if (bad !== 0 || bus.busy !== 1'b0 || bus.DAC_CSB !== 1'b1) begin
            miscompares = miscompares + 1;
            $display("FAIL gap ch%0d: bad gap cycles=%0d busy_after=%b, required 0 0",
                     ch, bad, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w;
        logic [15:0] exp_w;
        int low, rises, acks, g_prev, got;
        apply_reset();
        bus.data_a = 12'h5A5;
        bus.data_b = 12'hA5A;
        bus.req_a  = 1'b1;
        bus.req_b  = 1'b1;
        g_prev     = 0;
        for (int f = 0; f < 4; f++) begin
            got = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (bus.DAC_CSB === 1'b0) begin got = 1; break; end
            end
            vectors = vectors + 1;
            if ({bus.ack_a, bus.ack_b} !== ((f % 2 == 0) ? 2'b10 : 2'b01) || got !== 1) begin
                miscompares = miscompares + 1;
                $display("FAIL b2b_order frame%0d: ack_a/ack_b=%b%b started=%0d", f,
                         bus.ack_a, bus.ack_b, got);
            end
            if (f > 0) begin
                vectors = vectors + 1;
                if (cyc - g_prev !== 71) begin
                    miscompares = miscompares + 1;
                    $display("FAIL b2b_period frame%0d: %0d cycles, required 71", f, cyc - g_prev);
                end
            end
            g_prev = cyc;
            if (f == 3) begin
                bus.req_a = 1'b0;
                bus.req_b = 1'b0;
            end
            finish_frame(w, low, rises, acks);
            exp_w = (f % 2 == 0) ? 16'h35A5 : 16'hBA5A;
            vectors = vectors + 1;
            if (w !== exp_w) begin
                miscompares = miscompares + 1;
                $display("FAIL b2b_word frame%0d: got %h, required %h", f, w, exp_w);
            end
        end
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_midframe_b();
        logic [15:0] w;
        int low, rises, acks, g, ack_cyc, early;
        bus.data_a = 12'h0F0;
        bus.req_a  = 1'b1;
        tick();
        g = cyc;
        bus.req_a = 1'b0;
        early     = 0;
        ack_cyc   = -1;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (i == 19) begin
                bus.req_b  = 1'b1;
                bus.data_b = 12'h00F;
            end
            if (bus.ack_b === 1'b1) begin ack_cyc = cyc; break; end
        end
        vectors = vectors + 1;
        if (ack_cyc - g !== 71) begin
            miscompares = miscompares + 1;
            $display("FAIL midframe_ack_b: ack_b %0d cycles after A grant, required 71", ack_cyc - g);
        end
        bus.req_b = 1'b0;
        finish_frame(w, low, rises, acks);
        vectors = vectors + 1;
        if (w !== 16'hB00F || low !== 66) begin
            miscompares = miscompares + 1;
            $display("FAIL midframe_b_word: got %h low=%0d, required b00f 66", w, low);
        end
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_reset_midframe();
        logic [15:0] w;
        int low, rises, acks;
        logic prev;
        bus.data_a = 12'h456;
        bus.data_b = 12'h789;
        bus.req_a  = 1'b1;
        bus.req_b  = 1'b1;
        tick();
        vectors = vectors + 1;
        if (bus.ack_a !== 1'b1) begin
            miscompares = miscompares + 1;
            $display("FAIL pre_reset_grant: ack_a=%b, required 1", bus.ack_a);
        end
        rises = 0;
        prev  = bus.DAC_SCLK;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!prev && bus.DAC_SCLK) rises = rises + 1;
            prev = bus.DAC_SCLK;
            if (rises == 9) break;
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors = vectors + 1;
        if (bus.DAC_CSB !== 1'b1 || bus.DAC_SCLK !== 1'b0 || bus.busy !== 1'b0 ||
            bus.DAC_DIN !== 1'b0 || rises !== 9) begin
            miscompares = miscompares + 1;
            $display("FAIL async_abort: csb=%b sclk=%b busy=%b din=%b rises=%0d, required 1 0 0 0 9",
                     bus.DAC_CSB, bus.DAC_SCLK, bus.busy, bus.DAC_DIN, rises);
        end
        #1;
        reset_n = 1'b1;
        tick();
        vectors = vectors + 1;
        if ({bus.ack_a, bus.ack_b} !== 2'b10 || bus.DAC_CSB !== 1'b0) begin
            miscompares = miscompares + 1;
            $display("FAIL regrant_a: ack_a/ack_b=%b%b csb=%b, required 10 0",
                     bus.ack_a, bus.ack_b, bus.DAC_CSB);
        end
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        finish_frame(w, low, rises, acks);
        vectors = vectors + 1;
        if (w !== 16'h3456 || rises !== 16 || low !== 66) begin
            miscompares = miscompares + 1;
            $display("FAIL regrant_frame: word=%h rises=%0d low=%0d, required 3456 16 66",
                     w, rises, low);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        reset_n     = 1'b0;
        bus.req_a   = 1'b0;
        bus.req_b   = 1'b0;
        bus.data_a  = 12'h000;
        bus.data_b  = 12'h000;
        test_reset();
        test_single(1'b0, 12'hABC, 16'h3ABC);
        test_single(1'b1, 12'h123, 16'hB123);
        test_back_to_back();
        test_midframe_b();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dac_spi_scheduler.md
Name: dac_spi_scheduler

Overview:
- Shares the single dual-channel 12-bit SPI DAC (MCP4922-style, LDAC tied low) between two LFO waveform sources, channel A and channel B.
- Arbitrates requests round-robin, builds the 16-bit command word and serialises it MSB-first on DAC_CSB/DAC_SCLK/DAC_DIN.
- Sits between the LFO waveform cores and the GPIO_0[2:0] pins in the lfoGenerator top level.

Parameters:
- CLK_DIV, 25, CLOCK_50 cycles per SCLK half-period; 25 gives a 1 MHz SCLK; legal range 1..255.
- CS_GAP, 4, CLOCK_50 cycles that DAC_CSB stays high between frames; legal range 1..255.
- BUF, 0, value sent in command bit 14 (VREF buffer).
- GA_N, 1, value sent in command bit 13 (1 = 1x gain).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous active-low reset
- req_a  in  1  channel A update request; level, held until ack_a
- data_a  in  12  channel A sample; stable while req_a=1
- ack_a  out  1  one-cycle pulse; data_a captured, req_a may drop next cycle
- req_b  in  1  channel B request, same rules as A
- data_b  in  12  channel B sample
- ack_b  out  1  channel B capture pulse
- busy  out  1  1 whenever state != IDLE
- DAC_CSB  out  1  SPI chip select, active low
- DAC_SCLK  out  1  SPI clock; idles low; DAC samples on the rising edge
- DAC_DIN  out  1  SPI data; changes only while SCLK is low

Behaviour:
- Reset, asynchronous, any state:
  - Outputs: DAC_CSB=1, DAC_SCLK=0, DAC_DIN=0, ack_a=ack_b=0, busy=0.
  - State = IDLE, last_grant = B, so A wins the first tie.
  - A frame in progress is aborted; CSB rises immediately.
- Command word: {ch, BUF, GA_N, 1'b1 (SHDN_n), data[11:0]}, with ch=0 for A and ch=1 for B.
- All outputs are registered.
- States: IDLE, SETUP, SHIFT, GAP.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one req high: grant it.
  - Both high: grant the channel not in last_grant.
  - On grant, in the same cycle:
    - latch the command word into the shift register;
    - assert the matching ack for exactly that one cycle;
    - update last_grant;
    - next state = SETUP.
- Grant latency: one cycle from the cycle req is first sampled high (ack is registered). A req deasserted before its ack is ignored and no frame is sent.
- SETUP:
  - Entry cycle: DAC_CSB=0, DAC_DIN=word[15], DAC_SCLK=0.
  - Hold for CLK_DIV cycles, then go to SHIFT.
- SHIFT:
  - A half-period counter counts CLK_DIV cycles per phase.
  - Each expiry toggles SCLK.
  - On each falling toggle, shift left and drive the next bit on DIN; bit_cnt counts down 15..0.
  - After the 16th rising edge plus CLK_DIV cycles, SCLK falls: do not shift again; DIN=0, CSB=1, go to GAP.
  - CSB is low for exactly 33*CLK_DIV cycles per frame (SETUP plus 32 half-periods).
- GAP:
  - Hold CSB=1, SCLK=0 for CS_GAP cycles, then go to IDLE.
  - A request pending in GAP is granted on the first IDLE cycle.
- Requests arriving mid-frame wait; there is no preemption and no queueing beyond the req level.
- Back-to-back (both held): frames alternate A,B,A,B. Frame period = 33*CLK_DIV + CS_GAP + 1 cycles.
- Counter widths: 8-bit half-period counter, 4-bit bit counter; no wrap-around is possible within the legal parameter range.

Test Plan:
- Reset then idle (CLK_DIV=2, CS_GAP=4), no req for 100 cycles -> CSB=1, SCLK=0, DIN=0, busy=0, no ack.
- req_a=1, data_a=0xABC -> ack_a one cycle later, single pulse.
  - 16 SCLK rising edges sample 0x3ABC MSB-first.
  - CSB low for 66 cycles, then high for 4 cycles.
- req_b=1, data_b=0x123 -> sampled word 0xB123; ack_b only, ack_a stays 0.
- req_a and req_b asserted in the same cycle after reset, both held 4 frames -> sampled words in order 0x3..., 0xB..., 0x3..., 0xB...
  - Every frame start is 71 cycles apart.
- req_b raised mid-frame of A -> no ack_b until the first IDLE cycle after GAP; then a B frame follows.
- reset_n pulsed low during the 9th SCLK high phase -> CSB=1, SCLK=0 asynchronously, busy=0.
  - A held req_a is re-granted as A (last_grant reset to B), and a full 16-bit frame follows.
